sd_clk_gen: RTL and testbench

SD_CLK_GEN -- requirements
Module: sd_clk_gen

---
 rtl/sd_host_pkg.sv | 24 ++
 rtl/sd_clk_phase_counter.sv | 30 +++
 rtl/sd_clk_gen.sv | 170 +++++++++++++++++
 tb/tb_sd_clk_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: clock-generator FSM states, default divide counts
// and phase-length helpers.
package sd_host_pkg;

   localparam int unsigned SD_INIT_COUNT = 125;
   localparam int unsigned SD_MIN_COUNT  = 2;

   typedef enum logic [1:0] {
      SD_IDLE    = 2'd0,
      SD_HIGH    = 2'd1,
      SD_LOW     = 2'd2,
      SD_STOPPED = 2'd3
   } sd_clk_state_e;

   // High phase is the shorter half, so odd counts stretch the low phase.
   function automatic logic [15:0] sd_high_len(input logic [15:0] cnt);
      return {1'b0, cnt[15:1]};
   endfunction

   function automatic logic [15:0] sd_low_len(input logic [15:0] cnt);
      return cnt - {1'b0, cnt[15:1]};
   endfunction

endpackage

// File: rtl/sd_clk_phase_counter.sv
// Loadable 16-bit down-counter; expire is high while the count sits at zero,
// so loading N-1 yields a phase of N clk cycles.
module sd_clk_phase_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic        expire
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != 16'd0)
         cnt_d = cnt_q - 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= 16'd0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == 16'd0);

endmodule

// File: rtl/sd_clk_gen.sv
// SD card clock divider with glitch-free count switching at LOW-phase ends.
// Define SD_CLK_STOP_EN to enable the stop_req flow-control park state.
module sd_clk_gen
   import sd_host_pkg::*;
#(
   parameter int unsigned INIT_COUNT = SD_INIT_COUNT,
   parameter int unsigned MIN_COUNT  = SD_MIN_COUNT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] count,
   input  logic        ok,
   input  logic        err,
   input  logic        clk_en,
   input  logic        stop_req,
   output logic        sd_clk,
   output logic        sd_rise,
   output logic        sd_fall,
   output logic        switched,
   output logic        cfg_err,
   output logic [15:0] cur_count
);

   sd_clk_state_e state_q, state_d;
   logic          sd_clk_q, sd_clk_d;
   logic          sd_rise_q, sd_rise_d;
   logic          sd_fall_q, sd_fall_d;
   logic          switched_q, switched_d;
   logic          cfg_err_q, cfg_err_d;
   logic          pend_vld_q, pend_vld_d;
   logic [15:0]   pend_q, pend_d;
   logic [15:0]   cur_count_q, cur_count_d;

   logic          stop_w;
   logic          expire;
   logic          load;
   logic [15:0]   load_val;
   logic [15:0]   eff_count;
   logic          apply;

`ifdef SD_CLK_STOP_EN
   assign stop_w = stop_req;
`else
   logic unused_stop_req;
   assign unused_stop_req = stop_req;
   assign stop_w          = 1'b0;
`endif

   // A pending count only lands where no phase is in flight.
   assign apply     = pend_vld_q && ((state_q == SD_IDLE) || (state_q == SD_STOPPED) ||
                                     ((state_q == SD_LOW) && expire));
   assign eff_count = apply ? pend_q : cur_count_q;

   always_comb begin
      state_d     = state_q;
      sd_clk_d    = sd_clk_q;
      sd_rise_d   = 1'b0;
      sd_fall_d   = 1'b0;
      load        = 1'b0;
      load_val    = sd_high_len(eff_count) - 16'd1;
      switched_d  = apply;
      cur_count_d = eff_count;

      case (state_q)
         SD_IDLE: begin
            if (clk_en) begin
               state_d   = SD_HIGH;
               sd_clk_d  = 1'b1;
               sd_rise_d = 1'b1;
               load      = 1'b1;
            end
         end
         SD_HIGH: begin
            if (expire) begin
               state_d   = SD_LOW;
               sd_clk_d  = 1'b0;
               sd_fall_d = 1'b1;
               load      = 1'b1;
               load_val  = sd_low_len(eff_count) - 16'd1;
            end
         end
         SD_LOW: begin
            if (expire) begin
               if (!clk_en) begin
                  state_d = SD_IDLE;
               end else if (stop_w) begin
                  state_d = SD_STOPPED;
               end else begin
                  state_d   = SD_HIGH;
                  sd_clk_d  = 1'b1;
                  sd_rise_d = 1'b1;
                  load      = 1'b1;
               end
            end
         end
         SD_STOPPED: begin
            if (!clk_en) begin
               state_d = SD_IDLE;
            end else if (!stop_w) begin
               state_d   = SD_HIGH;
               sd_clk_d  = 1'b1;
               sd_rise_d = 1'b1;
               load      = 1'b1;
            end
         end
         default: begin
            state_d  = SD_IDLE;
            sd_clk_d = 1'b0;
         end
      endcase
   end

   // err wins over a coincident ok; a legal ok clears the sticky error.
   always_comb begin
      pend_vld_d = apply ? 1'b0 : pend_vld_q;
      pend_d     = pend_q;
      cfg_err_d  = cfg_err_q;
      if (err) begin
         cfg_err_d = 1'b1;
      end else if (ok) begin
         if (count >= 16'(MIN_COUNT)) begin
            cfg_err_d  = 1'b0;
            pend_d     = count;
            pend_vld_d = 1'b1;
         end else begin
            cfg_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SD_IDLE;
         sd_clk_q    <= 1'b0;
         sd_rise_q   <= 1'b0;
         sd_fall_q   <= 1'b0;
         switched_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_q      <= 16'd0;
         cur_count_q <= 16'(INIT_COUNT);
      end else begin
         state_q     <= state_d;
         sd_clk_q    <= sd_clk_d;
         sd_rise_q   <= sd_rise_d;
         sd_fall_q   <= sd_fall_d;
         switched_q  <= switched_d;
         cfg_err_q   <= cfg_err_d;
         pend_vld_q  <= pend_vld_d;
         pend_q      <= pend_d;
         cur_count_q <= cur_count_d;
      end
   end

   sd_clk_phase_counter u_phase (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   assign sd_clk    = sd_clk_q;
   assign sd_rise   = sd_rise_q;
   assign sd_fall   = sd_fall_q;
   assign switched  = switched_q;
   assign cfg_err   = cfg_err_q;
   assign cur_count = cur_count_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: divide periods, count switching, error
// handling, stop/park behaviour (SD_CLK_STOP_EN) and asynchronous reset.
module tb_sd_clk_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] count = 16'd0;
   logic        ok = 1'b0;
   logic        err = 1'b0;
   logic        clk_en = 1'b0;
   logic        stop_req = 1'b0;
   logic        sd_clk, sd_rise, sd_fall, switched, cfg_err;
   logic [15:0] cur_count;

   int n_cmp = 0;
   int n_bad = 0;
   int sw_cnt = 0;

   sd_clk_gen dut (
      .clk       (clk),
      .reset     (reset),
      .count     (count),
      .ok        (ok),
      .err       (err),
      .clk_en    (clk_en),
      .stop_req  (stop_req),
      .sd_clk    (sd_clk),
      .sd_rise   (sd_rise),
      .sd_fall   (sd_fall),
      .switched  (switched),
      .cfg_err   (cfg_err),
      .cur_count (cur_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (switched === 1'b1) sw_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sync to a rise, then count one full high and low phase plus strobes.
   task automatic measure(output int h, output int l, output int r, output int f, output bit t);
      int n;
      n = 0; h = 0; l = 0; r = 0; f = 0; t = 1'b0;
      while (sd_rise !== 1'b1 && n < 2000) begin tick(); n++; end
      if (sd_rise !== 1'b1) t = 1'b1;
      while (sd_clk === 1'b1 && h < 2000) begin
         if (sd_rise === 1'b1) r++;
         if (sd_fall === 1'b1) f++;
         h++; tick();
      end
      while (sd_clk === 1'b0 && l < 2000) begin
         if (sd_rise === 1'b1) r++;
         if (sd_fall === 1'b1) f++;
         l++; tick();
      end
      if (h >= 2000 || l >= 2000) t = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  hi, lo, nr, nf, k, sw0, rises, falls;
      bit  to;

      // Asynchronous reset, checked before any clock edge
      #2 reset = 1'b0;
      #1;
      chk("rst_sd_clk", sd_clk, 0);
      chk("rst_rise", sd_rise, 0);
      chk("rst_fall", sd_fall, 0);
      chk("rst_switched", switched, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_cur_count", cur_count, 125);
      tick(); tick();

      // Release with clk_en=1: 62 high, 63 low
      clk_en = 1'b1;
      reset  = 1'b1;
      measure(hi, lo, nr, nf, to);
      chk("p125_timeout", to, 0);
      chk("p125_high", hi, 62);
      chk("p125_low", lo, 63);
      chk("p125_rise_cnt", nr, 1);
      chk("p125_fall_cnt", nf, 1);
      chk("p125_next_rise", sd_rise, 1);

      // count=2 mid-HIGH: current period completes untouched, then 25 MHz
      repeat (10) tick();
      ok = 1'b1; count = 16'd2;
      tick();
      ok = 1'b0;
      sw0 = sw_cnt;
      k = 0;
      while (sd_fall !== 1'b1 && k < 200) begin tick(); k++; end
      chk("sw2_high_full", 11 + k, 62);
      chk("sw2_cur_before", cur_count, 125);
      lo = 0;
      while (sd_clk === 1'b0 && lo < 200) begin lo++; tick(); end
      chk("sw2_low_full", lo, 63);
      chk("sw2_switched", switched, 1);
      chk("sw2_cur_after", cur_count, 2);
      chk("sw2_rise", sd_rise, 1);
      measure(hi, lo, nr, nf, to);
      chk("p2_high", hi, 1);
      chk("p2_low", lo, 1);
      chk("sw2_once", sw_cnt - sw0, 1);

      // Illegal count=1 sets cfg_err, leaves cur_count; count=4 clears it
      ok = 1'b1; count = 16'd1;
      tick();
      ok = 1'b0;
      chk("bad1_cfg_err", cfg_err, 1);
      chk("bad1_cur", cur_count, 2);
      ok = 1'b1; count = 16'd4;
      tick();
      ok = 1'b0;
      chk("ok4_cfg_err", cfg_err, 0);
      measure(hi, lo, nr, nf, to);
      measure(hi, lo, nr, nf, to);
      chk("p4_high", hi, 2);
      chk("p4_low", lo, 2);
      chk("p4_cur", cur_count, 4);

      // ok and err together: error only, nothing pending
      ok = 1'b1; err = 1'b1; count = 16'd10;
      tick();
      ok = 1'b0; err = 1'b0;
      chk("okerr_cfg_err", cfg_err, 1);
      sw0 = sw_cnt;
      repeat (3) measure(hi, lo, nr, nf, to);
      chk("okerr_timeout", to, 0);
      chk("okerr_high", hi, 2);
      chk("okerr_low", lo, 2);
      chk("okerr_cur", cur_count, 4);
      chk("okerr_no_switch", sw_cnt - sw0, 0);

      // stop_req asserted mid-HIGH
      tick();
      stop_req = 1'b1;
      rises = 0;
      repeat (20) begin tick(); if (sd_rise === 1'b1) rises++; end
`ifdef SD_CLK_STOP_EN
      chk("stop_no_rise", rises, 0);
      chk("stop_parked", sd_clk, 0);
      stop_req = 1'b0;
      tick();
      chk("stop_release_rise", sd_rise, 1);
      chk("stop_release_clk", sd_clk, 1);
`else
      chk("nostop_rises", rises, 5);
      stop_req = 1'b0;
      tick();
      chk("nostop_fall", sd_fall, 1);
`endif

      // count=8 active, reset asserted mid-HIGH
      ok = 1'b1; count = 16'd8;
      tick();
      ok = 1'b0;
      k = 0;
      while (switched !== 1'b1 && k < 100) begin tick(); k++; end
      chk("sw8_seen", switched, 1);
      measure(hi, lo, nr, nf, to);
      chk("p8_high", hi, 4);
      chk("p8_low", lo, 4);
      tick(); tick();
      chk("p8_mid_high", sd_clk, 1);
      #1 reset = 1'b0;
      #1;
      chk("arst_sd_clk", sd_clk, 0);
      chk("arst_cur", cur_count, 125);
      tick(); tick();
      reset = 1'b1;
      measure(hi, lo, nr, nf, to);
      chk("post_rst_timeout", to, 0);
      chk("post_rst_high", hi, 62);
      chk("post_rst_low", lo, 63);

      // clk_en drop finishes the period, then parks in IDLE
      clk_en = 1'b0;
      rises = 0; falls = 0;
      repeat (130) begin
         tick();
         if (sd_rise === 1'b1) rises++;
         if (sd_fall === 1'b1) falls++;
      end
      chk("den_rises", rises, 0);
      chk("den_falls", falls, 1);
      chk("den_parked", sd_clk, 0);
      clk_en = 1'b1;
      tick();
      chk("en_rise", sd_rise, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
